irq_controller: RTL and testbench

Machine-level interrupt source and arbiter feeding the trap handler's `irq_en`/`irq_code`/`irq_val` inputs. Holds the memory-mapped timer (`mtime`/`mtimecmp`), the software-interrupt bit (`msip`) and a synchronised external line, and gates them with `mie`, `mstatus.MIE` and the current privilege. It presents one prioritised request at a time and holds it until the trap handler acknowledges with `trap_taken`. It blocks further requests until `mret`.

---
 rtl/irq_controller.sv | 190 +++++++++++++++++++
 tb/tb_irq_controller.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
`timescale 1ns/1ps
// irq_controller
//
// Machine-level interrupt source and arbiter for the trap handler. Holds the
// memory-mapped timer (mtime/mtimecmp), the software-interrupt bit (msip) and
// a synchronised external line. Pending sources are gated by mie,
// mstatus.MIE and privilege. One prioritised request is presented at a time
// and held until trap_taken. No new request is raised until mret.
//
// Parameters:
//   TICK_DIV     mtime increments once every TICK_DIV clk cycles (>= 1)
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous reset, active low
//   reg_we       register write strobe
//   reg_sel      0 = mtime, 1 = mtimecmp, 2 = msip (bit 0), 3 = none
//   reg_wdata    write data
//   reg_rdata    selected register, one cycle after reg_sel (sel 3 reads 0)
//   ext_irq      asynchronous external interrupt level
//   mie          CSR mie (bits 3, 7, 11 used)
//   mstatus_mie  mstatus[3]
//   priv_lvl     current privilege level
//   trap_taken   trap-entry pulse
//   mret         trap-return strobe
//   irq_en       interrupt request
//   irq_code     cause code (11, 3 or 7)
//   irq_val      always 0 (mtval for interrupts)
//   mip          pending bits: 11 MEIP, 7 MTIP, 3 MSIP
//   mtime_o      current mtime
module irq_controller #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_we,
  input  logic [1:0]  reg_sel,
  input  logic [63:0] reg_wdata,
  output logic [63:0] reg_rdata,
  input  logic        ext_irq,
  input  logic [63:0] mie,
  input  logic        mstatus_mie,
  input  logic [1:0]  priv_lvl,
  input  logic        trap_taken,
  input  logic        mret,
  output logic        irq_en,
  output logic [3:0]  irq_code,
  output logic [63:0] irq_val,
  output logic [63:0] mip,
  output logic [63:0] mtime_o
);

  localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  logic [PW-1:0] presc;
  logic [63:0]   mtime;
  logic [63:0]   mtimecmp;
  logic          msip;
  logic          sync1;
  logic          sync2;
  logic [1:0]    state;

  logic          mtip;
  logic          gie;
  logic          pend_ext;
  logic          pend_sw;
  logic          pend_tmr;
  logic [3:0]    cand_code;
  logic          cand_valid;
  logic          latched_live;
  logic          unused_mie;

  // A register write to mtime takes precedence over the tick and restarts
  // the prescaler so the next increment is a full TICK_DIV cycles away.
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc <= '0;
      mtime <= '0;
    end else if (reg_we && reg_sel == 2'd0) begin
      presc <= '0;
      mtime <= reg_wdata;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      mtime <= mtime + 64'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mtimecmp <= '1;
      msip     <= 1'b0;
    end else if (reg_we) begin
      if (reg_sel == 2'd1) mtimecmp <= reg_wdata;
      if (reg_sel == 2'd2) msip     <= reg_wdata[0];
    end
  end

  // Two-flop synchroniser for the asynchronous external line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= ext_irq;
      sync2 <= sync1;
    end
  end

  // Read data reflects register contents before any same-cycle write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_rdata <= '0;
    end else begin
      case (reg_sel)
        2'd0:    reg_rdata <= mtime;
        2'd1:    reg_rdata <= mtimecmp;
        2'd2:    reg_rdata <= {63'd0, msip};
        default: reg_rdata <= '0;
      endcase
    end
  end

  assign mtip = (mtime >= mtimecmp);
  assign mip  = {52'd0, sync2, 3'd0, mtip, 3'd0, msip, 3'd0};

  assign gie      = (priv_lvl != 2'b11) | mstatus_mie;
  assign pend_ext = sync2 & mie[11];
  assign pend_sw  = msip  & mie[3];
  assign pend_tmr = mtip  & mie[7];

  assign unused_mie = ^{mie[63:12], mie[10:8], mie[6:4], mie[2:0]};

  // Fixed priority: external > software > timer.
  always_comb begin
    cand_code = 4'd0;
    if (pend_ext)      cand_code = 4'd11;
    else if (pend_sw)  cand_code = 4'd3;
    else if (pend_tmr) cand_code = 4'd7;
  end

  assign cand_valid = gie && (cand_code != 4'd0);

  // Whether the source that was latched into irq_code is still asserted.
  always_comb begin
    latched_live = 1'b0;
    case (irq_code)
      4'd11:   latched_live = pend_ext;
      4'd3:    latched_live = pend_sw;
      4'd7:    latched_live = pend_tmr;
      default: latched_live = 1'b0;
    endcase
  end

  // trap_taken wins over withdrawal so a request that is acknowledged in the
  // same cycle it would have been dropped still enters SERVICE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      irq_code <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cand_valid) begin
            state    <= S_REQ;
            irq_code <= cand_code;
          end
        end
        S_REQ: begin
          if (trap_taken)                state <= S_SERVICE;
          else if (!gie || !latched_live) state <= S_IDLE;
        end
        S_SERVICE: begin
          if (mret) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign irq_en  = (state == S_REQ);
  assign irq_val = '0;
  assign mtime_o = mtime;

endmodule

// File: tb/tb_irq_controller.sv
`timescale 1ns/1ps
// tb_irq_controller
//
// Drives two controllers (TICK_DIV = 1 and 4) from the same inputs and checks
// every cycle against a behavioural model. The model tracks time as
// "value last written + elapsed cycles / TICK_DIV" and the arbiter as the
// pending cause code plus an in-service flag. Directed scenarios add literal
// expectations on top of the model.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_we;
  logic [1:0]  reg_sel;
  logic [63:0] reg_wdata;
  logic        ext_irq;
  logic [63:0] mie;
  logic        mstatus_mie;
  logic [1:0]  priv_lvl;
  logic        trap_taken;
  logic        mret;

  logic        d1_irq_en,    d4_irq_en;
  logic [3:0]  d1_irq_code,  d4_irq_code;
  logic [63:0] d1_irq_val,   d4_irq_val;
  logic [63:0] d1_mip,       d4_mip;
  logic [63:0] d1_mtime,     d4_mtime;
  logic [63:0] d1_rdata,     d4_rdata;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  always #5 clk = ~clk;

  irq_controller #(.TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .reg_we(reg_we), .reg_sel(reg_sel),
    .reg_wdata(reg_wdata), .reg_rdata(d1_rdata), .ext_irq(ext_irq),
    .mie(mie), .mstatus_mie(mstatus_mie), .priv_lvl(priv_lvl),
    .trap_taken(trap_taken), .mret(mret), .irq_en(d1_irq_en),
    .irq_code(d1_irq_code), .irq_val(d1_irq_val), .mip(d1_mip),
    .mtime_o(d1_mtime)
  );

  irq_controller #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .reg_we(reg_we), .reg_sel(reg_sel),
    .reg_wdata(reg_wdata), .reg_rdata(d4_rdata), .ext_irq(ext_irq),
    .mie(mie), .mstatus_mie(mstatus_mie), .priv_lvl(priv_lvl),
    .trap_taken(trap_taken), .mret(mret), .irq_en(d4_irq_en),
    .irq_code(d4_irq_code), .irq_val(d4_irq_val), .mip(d4_mip),
    .mtime_o(d4_mtime)
  );

  // Model state: req is the cause code currently requested (0 = none).
  typedef struct {
    logic [63:0]     base;
    longint unsigned elapsed;
    logic [63:0]     cmp;
    logic            sw;
    logic            ext_d1;
    logic            ext_d2;
    logic [3:0]      req;
    logic            serving;
    logic [3:0]      code;
    logic [63:0]     rdata;
  } model_t;

  model_t m1;
  model_t m4;

  function automatic logic [63:0] m_time(input model_t m, input int div);
    return m.base + (m.elapsed / 64'(div));
  endfunction

  function automatic logic [63:0] m_mip(input model_t m, input int div);
    logic [63:0] r;
    r     = '0;
    r[11] = m.ext_d2;
    r[7]  = (m_time(m, div) >= m.cmp);
    r[3]  = m.sw;
    return r;
  endfunction

  function automatic bit m_gie();
    return (priv_lvl != 2'b11) || (mstatus_mie == 1'b1);
  endfunction

  function automatic logic [3:0] m_pick(input logic [63:0] p);
    if (p[11]) return 4'd11;
    if (p[3])  return 4'd3;
    if (p[7])  return 4'd7;
    return 4'd0;
  endfunction

  function automatic model_t m_step(input model_t m, input int div);
    model_t      n;
    logic [63:0] pend;
    n    = m;
    pend = m_mip(m, div) & mie;
    if (!rst) begin
      n.base = '0; n.elapsed = 0; n.cmp = '1; n.sw = 1'b0;
      n.ext_d1 = 1'b0; n.ext_d2 = 1'b0; n.req = 4'd0; n.serving = 1'b0;
      n.code = 4'd0; n.rdata = '0;
      return n;
    end
    case (reg_sel)
      2'd0:    n.rdata = m_time(m, div);
      2'd1:    n.rdata = m.cmp;
      2'd2:    n.rdata = {63'd0, m.sw};
      default: n.rdata = '0;
    endcase
    n.elapsed = m.elapsed + 1;
    if (reg_we) begin
      if (reg_sel == 2'd0) begin n.base = reg_wdata; n.elapsed = 0; end
      if (reg_sel == 2'd1) n.cmp = reg_wdata;
      if (reg_sel == 2'd2) n.sw  = reg_wdata[0];
    end
    n.ext_d1 = ext_irq;
    n.ext_d2 = m.ext_d1;
    if (m.serving) begin
      if (mret) n.serving = 1'b0;
    end else if (m.req != 4'd0) begin
      if (trap_taken) begin
        n.serving = 1'b1;
        n.req     = 4'd0;
      end else if (!m_gie() || !pend[m.req]) begin
        n.req = 4'd0;
      end
    end else if (m_gie() && m_pick(pend) != 4'd0) begin
      n.req  = m_pick(pend);
      n.code = n.req;
    end
    return n;
  endfunction

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    compare("d1_irq_en",   d1_irq_en,   {63'd0, m1.req != 4'd0});
    compare("d1_irq_code", d1_irq_code, m1.code);
    compare("d1_irq_val",  d1_irq_val,  64'd0);
    compare("d1_mip",      d1_mip,      m_mip(m1, 1));
    compare("d1_mtime",    d1_mtime,    m_time(m1, 1));
    compare("d1_rdata",    d1_rdata,    m1.rdata);
    compare("d4_irq_en",   d4_irq_en,   {63'd0, m4.req != 4'd0});
    compare("d4_irq_code", d4_irq_code, m4.code);
    compare("d4_irq_val",  d4_irq_val,  64'd0);
    compare("d4_mip",      d4_mip,      m_mip(m4, 4));
    compare("d4_mtime",    d4_mtime,    m_time(m4, 4));
    compare("d4_rdata",    d4_rdata,    m4.rdata);
  endtask

  // One clock: the model advances at the edge, outputs are checked mid-cycle.
  task automatic tick();
    @(posedge clk);
    m1 = m_step(m1, 1);
    m4 = m_step(m4, 4);
    if (!rst) started = 1'b1;
    @(negedge clk);
    if (started) checkOutput();
  endtask

  task automatic write_reg(input logic [1:0] sel, input logic [63:0] data);
    reg_we    = 1'b1;
    reg_sel   = sel;
    reg_wdata = data;
    tick();
    reg_we    = 1'b0;
    reg_sel   = 2'd3;
  endtask

  task automatic pulse_trap();
    trap_taken = 1'b1;
    tick();
    trap_taken = 1'b0;
  endtask

  task automatic pulse_mret();
    mret = 1'b1;
    tick();
    mret = 1'b0;
  endtask

  task automatic wait_en(input string name, input int budget, input logic want);
    int n;
    n = 0;
    while (d1_irq_en !== want && n < budget) begin
      tick();
      n++;
    end
    compare(name, {63'd0, d1_irq_en}, {63'd0, want});
  endtask

  task automatic applyStimulus();
    rst    = ($urandom_range(0, 199) != 0);
    reg_we = ($urandom_range(0, 3) == 0);
    reg_sel = 2'($urandom_range(0, 3));
    case (reg_sel)
      2'd0:    reg_wdata = 64'($urandom_range(0, 60));
      2'd1:    reg_wdata = ($urandom_range(0, 7) == 0) ? '1 : 64'($urandom_range(0, 80));
      default: reg_wdata = {$urandom(), $urandom()};
    endcase
    if ($urandom_range(0, 9) == 0)  ext_irq     = ~ext_irq;
    if ($urandom_range(0, 15) == 0) mie         = {$urandom(), $urandom()};
    if ($urandom_range(0, 9) == 0)  mstatus_mie = ~mstatus_mie;
    if ($urandom_range(0, 11) == 0) priv_lvl    = 2'($urandom_range(0, 3));
    trap_taken = ($urandom_range(0, 5) == 0);
    mret       = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] prev;
    int          n;

    rst = 1'b0; reg_we = 1'b0; reg_sel = 2'd3; reg_wdata = '0;
    ext_irq = 1'b0; mie = '0; mstatus_mie = 1'b0; priv_lvl = 2'b11;
    trap_taken = 1'b0; mret = 1'b0;
    @(negedge clk);

    // Reset and free-running time.
    repeat (3) tick();
    compare("rst_irq_en", {63'd0, d1_irq_en}, 64'd0);
    compare("rst_mip", d1_mip, 64'd0);
    compare("rst_mtime0", d1_mtime, 64'd0);
    rst     = 1'b1;
    reg_sel = 2'd1;
    tick();
    compare("rst_cmp_read", d1_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    compare("rst_mtime1", d1_mtime, 64'd1);
    reg_sel = 2'd3;
    tick();
    compare("rst_mtime2", d1_mtime, 64'd2);

    // Timer interrupt, acknowledge, and re-request after mret.
    mie = 64'd1 << 7; mstatus_mie = 1'b1; priv_lvl = 2'b11;
    write_reg(2'd1, 64'd10);
    n = 0;
    while (d1_mtime !== 64'd10 && n < 30) begin tick(); n++; end
    compare("tmr_reach10", d1_mtime, 64'd10);
    tick();
    compare("tmr_en", {63'd0, d1_irq_en}, 64'd1);
    compare("tmr_code", {60'd0, d1_irq_code}, 64'd7);
    pulse_trap();
    compare("tmr_ack", {63'd0, d1_irq_en}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      compare("tmr_held", {63'd0, d1_irq_en}, 64'd0);
    end
    pulse_mret();
    compare("tmr_mret_idle", {63'd0, d1_irq_en}, 64'd0);
    tick();
    compare("tmr_rereq", {63'd0, d1_irq_en}, 64'd1);
    compare("tmr_rereq_code", {60'd0, d1_irq_code}, 64'd7);
    pulse_trap();
    write_reg(2'd1, '1);
    pulse_mret();
    tick();
    compare("tmr_quiet", {63'd0, d1_irq_en}, 64'd0);

    // Priority: external and software become pending in the same cycle.
    mie = (64'd1 << 3) | (64'd1 << 11);
    ext_irq = 1'b1;
    tick();
    write_reg(2'd2, 64'd1);
    wait_en("pri_first_en", 4, 1'b1);
    compare("pri_first_code", {60'd0, d1_irq_code}, 64'd11);
    pulse_trap();
    ext_irq = 1'b0;
    repeat (3) tick();
    pulse_mret();
    wait_en("pri_second_en", 4, 1'b1);
    compare("pri_second_code", {60'd0, d1_irq_code}, 64'd3);
    pulse_trap();
    write_reg(2'd2, 64'd0);
    pulse_mret();

    // Gating by mstatus.MIE in machine mode, opened by dropping privilege.
    mie = 64'd1 << 3; mstatus_mie = 1'b0; priv_lvl = 2'b11;
    write_reg(2'd2, 64'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      compare("gate_blocked", {63'd0, d1_irq_en}, 64'd0);
    end
    priv_lvl = 2'b00;
    wait_en("gate_open_en", 2, 1'b1);
    compare("gate_open_code", {60'd0, d1_irq_code}, 64'd3);
    pulse_trap();
    write_reg(2'd2, 64'd0);
    pulse_mret();
    mstatus_mie = 1'b1; priv_lvl = 2'b11;

    // Withdraw before acknowledge; a stray trap_taken is then ignored.
    write_reg(2'd2, 64'd1);
    wait_en("wd_req", 3, 1'b1);
    write_reg(2'd2, 64'd0);
    tick();
    compare("wd_dropped", {63'd0, d1_irq_en}, 64'd0);
    pulse_trap();
    compare("wd_stray_trap", {63'd0, d1_irq_en}, 64'd0);
    write_reg(2'd2, 64'd1);
    wait_en("wd_not_serving", 3, 1'b1);
    write_reg(2'd2, 64'd0);
    repeat (2) tick();

    // mtime wrap and write/tick collision.
    mie = '0;
    write_reg(2'd0, '1);
    compare("wrap_allones", d1_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    compare("wrap_zero", d1_mtime, 64'd0);
    prev = d4_mtime;
    n = 0;
    while (d4_mtime === prev && n < 10) begin tick(); n++; end
    repeat (3) tick();
    write_reg(2'd0, 64'd100);
    compare("col_write", d4_mtime, 64'd100);
    for (int i = 0; i < 3; i++) begin
      tick();
      compare("col_hold", d4_mtime, 64'd100);
    end
    tick();
    compare("col_inc", d4_mtime, 64'd101);

    // Reset asserted while a request is up.
    mie = 64'd1 << 3;
    write_reg(2'd2, 64'd1);
    wait_en("rstreq_en", 3, 1'b1);
    rst = 1'b0;
    tick();
    compare("rstreq_drop", {63'd0, d1_irq_en}, 64'd0);
    rst = 1'b1;
    tick();

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
